// File: rtl/tl_mem_slv.sv
// TileLink-UL slave memory: 2^14 x 128-bit RAM serving single/multi-beat Get,
// PutFullData and PutPartialData, one transaction at a time.
module tl_mem_slv #(
  parameter int DW    = 128,
  parameter int AW    = 32,
  parameter int DP    = 16384,
  parameter int MAXSZ = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          tlslv_a_valid,
  output logic          tlslv_a_ready,
  input  logic [2:0]    tlslv_a_opcode,
  input  logic [2:0]    tlslv_a_param,
  input  logic [7:0]    tlslv_a_size,
  input  logic [2:0]    tlslv_a_source,
  input  logic [AW-1:0] tlslv_a_address,
  input  logic [DW/8-1:0] tlslv_a_mask,
  input  logic [DW-1:0] tlslv_a_data,
  input  logic          tlslv_a_corrupt,
  output logic          tlslv_d_valid,
  input  logic          tlslv_d_ready,
  output logic [2:0]    tlslv_d_opcode,
  output logic [1:0]    tlslv_d_param,
  output logic [7:0]    tlslv_d_size,
  output logic [2:0]    tlslv_d_source,
  output logic [2:0]    tlslv_d_sink,
  output logic          tlslv_d_denied,
  output logic [DW-1:0] tlslv_d_data,
  output logic          tlslv_d_corrupt
);

  localparam int IW = $clog2(DP);
  localparam int NB = DW / 8;
  localparam int BW = MAXSZ - 4;

  typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   beat, beat_nxt;
  logic            denied_q, denied_nxt;
  logic [7:0]      size_q;
  logic [2:0]      src_q;
  logic [IW-1:0]   base_q;

  logic [DW-1:0]   ram [0:DP-1];

  logic            a_fire, d_fire;
  logic            is_get, is_put, size_ok;
  logic [BW-1:0]   last_a, last_q;
  logic [IW-1:0]   cur_idx, wr_idx;
  logic            wr_en;
  logic            unused;

  // Index of the final beat: 0 for transfers up to one word, else 2^(size-4)-1.
  function automatic logic [BW-1:0] last_beat(input logic [7:0] size);
    logic [15:0] n;
    if (size <= 8'd4) n = 16'd0;
    else              n = (16'd1 << (size - 8'd4)) - 16'd1;
    return n[BW-1:0];
  endfunction

  assign unused = ^{tlslv_a_param, tlslv_a_corrupt,
                    tlslv_a_address[AW-1:IW+4], tlslv_a_address[3:0]};

  assign a_fire  = tlslv_a_valid & tlslv_a_ready;
  assign d_fire  = tlslv_d_valid & tlslv_d_ready;
  assign is_get  = (tlslv_a_opcode == 3'd4);
  assign is_put  = (tlslv_a_opcode == 3'd0) | (tlslv_a_opcode == 3'd1);
  assign size_ok = (tlslv_a_size <= 8'(MAXSZ));
  assign last_a  = last_beat(tlslv_a_size);
  assign last_q  = last_beat(size_q);
  assign cur_idx = base_q + {{(IW-BW){1'b0}}, beat};

  assign wr_en  = a_fire & ((state == WR) | ((state == IDLE) & is_put & size_ok));
  assign wr_idx = (state == IDLE) ? tlslv_a_address[IW+3:4] : cur_idx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      beat     <= '0;
      denied_q <= 1'b0;
      size_q   <= '0;
      src_q    <= '0;
      base_q   <= '0;
    end else begin
      state    <= state_nxt;
      beat     <= beat_nxt;
      denied_q <= denied_nxt;
      if (state == IDLE && a_fire) begin
        size_q <= tlslv_a_size;
        src_q  <= tlslv_a_source;
        base_q <= tlslv_a_address[IW+3:4];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat;
    denied_nxt = denied_q;
    case (state)
      IDLE: if (a_fire) begin
        beat_nxt = '0;
        if (is_get && size_ok) begin
          state_nxt = RD;
        end else if (is_put && size_ok) begin
          if (last_a == '0) begin
            state_nxt = ACK;
          end else begin
            state_nxt = WR;
            beat_nxt  = BW'(1);
          end
        end else begin
          denied_nxt = 1'b1;
          state_nxt  = ACK;
        end
      end
      WR: if (a_fire) begin
        if (beat == last_q) begin
          state_nxt = ACK;
          beat_nxt  = '0;
        end else begin
          beat_nxt = beat + BW'(1);
        end
      end
      RD: if (d_fire) begin
        if (beat == last_q) begin
          state_nxt = IDLE;
          beat_nxt  = '0;
        end else begin
          beat_nxt = beat + BW'(1);
        end
      end
      ACK: if (d_fire) begin
        state_nxt  = IDLE;
        denied_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tlslv_a_ready   = rstn & ((state == IDLE) | (state == WR));
    tlslv_d_valid   = (state == RD) | (state == ACK);
    tlslv_d_opcode  = (state == RD) ? 3'd1 : 3'd0;
    tlslv_d_data    = (state == RD) ? ram[cur_idx] : '0;
    tlslv_d_param   = '0;
    tlslv_d_sink    = '0;
    tlslv_d_corrupt = 1'b0;
    tlslv_d_size    = size_q;
    tlslv_d_source  = src_q;
    tlslv_d_denied  = denied_q;
  end

  // Plain always (no reset) so the harness can preload ram hierarchically.
  always @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (tlslv_a_mask[b]) ram[wr_idx][b*8 +: 8] <= tlslv_a_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_tl_mem_slv.sv
// Randomized self-checking bench for tl_mem_slv against an array-based memory
// model that applies TileLink-UL Get/Put rules directly.
module tb_tl_mem_slv;

  localparam int DP = 16384;

  logic         clk = 1'b0;
  logic         rstn;
  logic         a_valid, a_ready;
  logic [2:0]   a_opcode, a_param, a_source;
  logic [7:0]   a_size;
  logic [31:0]  a_address;
  logic [15:0]  a_mask;
  logic [127:0] a_data;
  logic         a_corrupt;
  logic         d_valid, d_ready;
  logic [2:0]   d_opcode, d_source, d_sink;
  logic [1:0]   d_param;
  logic [7:0]   d_size;
  logic         d_denied, d_corrupt;
  logic [127:0] d_data;

  logic [127:0] model [DP];
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  tl_mem_slv dut (
    .clk(clk), .rstn(rstn),
    .tlslv_a_valid(a_valid), .tlslv_a_ready(a_ready),
    .tlslv_a_opcode(a_opcode), .tlslv_a_param(a_param),
    .tlslv_a_size(a_size), .tlslv_a_source(a_source),
    .tlslv_a_address(a_address), .tlslv_a_mask(a_mask),
    .tlslv_a_data(a_data), .tlslv_a_corrupt(a_corrupt),
    .tlslv_d_valid(d_valid), .tlslv_d_ready(d_ready),
    .tlslv_d_opcode(d_opcode), .tlslv_d_param(d_param),
    .tlslv_d_size(d_size), .tlslv_d_source(d_source),
    .tlslv_d_sink(d_sink), .tlslv_d_denied(d_denied),
    .tlslv_d_data(d_data), .tlslv_d_corrupt(d_corrupt)
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int beats_of(input int size);
    return (size <= 4) ? 1 : (1 << (size - 4));
  endfunction

  // Present one A beat and hold it until accepted (bounded).
  task automatic send_a(input logic [2:0] op, input logic [7:0] size, input logic [2:0] src,
                        input logic [31:0] addr, input logic [15:0] mask,
                        input logic [127:0] data, output bit ok);
    int waited = 0;
    a_opcode = op; a_size = size; a_source = src; a_address = addr;
    a_mask = mask; a_data = data; a_param = 3'($urandom); a_corrupt = 1'($urandom);
    a_valid = 1'b1;
    while (!a_ready && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    ok = a_ready;
    if (!ok) begin
      checkOutput("a_accept_timeout", 128'(a_ready), 128'd1);
      a_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  // Expect a D beat right now; optionally stall it, then check and accept it.
  task automatic recv_d(input logic [2:0] op, input logic [127:0] data, input logic [2:0] src,
                        input logic [7:0] size, input logic denied, input int stall);
    int waited = 0;
    logic [127:0] snap;
    d_ready = 1'b0;
    checkOutput("d_valid_on_time", 128'(d_valid), 128'd1);
    while (!d_valid && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    if (!d_valid) return;
    snap = d_data;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      checkOutput("d_hold_valid", 128'(d_valid), 128'd1);
      checkOutput("d_hold_data", d_data, snap);
    end
    checkOutput("d_opcode", 128'(d_opcode), 128'(op));
    checkOutput("d_data", d_data, data);
    checkOutput("d_source", 128'(d_source), 128'(src));
    checkOutput("d_size", 128'(d_size), 128'(size));
    checkOutput("d_denied", 128'(d_denied), 128'(denied));
    checkOutput("d_const", 128'({d_param, d_sink, d_corrupt}), 128'd0);
    d_ready = 1'b1;
    @(posedge clk); #1;
    d_ready = 1'b0;
  endtask

  // One complete transaction, with the memory model updated from the TL rules.
  task automatic applyStimulus(input int op, input int size, input int src, input logic [31:0] addr,
                               input logic [127:0] datas[$], input logic [15:0] masks[$],
                               input int stall);
    bit ok;
    int base = int'(addr[17:4]);
    bit size_ok = (size <= 8);
    bit supported = size_ok && (op == 0 || op == 1 || op == 4);
    int n = supported ? beats_of(size) : 1;
    logic [15:0] m;
    logic [127:0] w;
    int idx;
    if (op == 4 && size_ok) begin
      send_a(3'd4, 8'(size), 3'(src), addr, 16'h0, '0, ok);
      if (!ok) return;
      for (int b = 0; b < n; b++) begin
        idx = (base + b) % DP;
        recv_d(3'd1, model[idx], 3'(src), 8'(size), 1'b0, stall);
      end
    end else begin
      for (int b = 0; b < n; b++) begin
        m = masks[b]; w = datas[b];
        send_a(3'(op), 8'(size), 3'(src), (b == 0) ? addr : 32'($urandom), m, w, ok);
        if (!ok) return;
        if (supported) begin
          idx = (base + b) % DP;
          for (int l = 0; l < 16; l++)
            if (m[l]) model[idx][l*8 +: 8] = w[l*8 +: 8];
        end
        if (b < n - 1) begin
          checkOutput("put_no_early_ack", 128'(d_valid), 128'd0);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
      end
      recv_d(3'd0, '0, 3'(src), 8'(size), !supported, stall);
    end
    checkOutput("idle_a_ready", 128'(a_ready), 128'd1);
    checkOutput("idle_d_valid", 128'(d_valid), 128'd0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] dq[$];
    logic [15:0]  mq[$];
    logic [127:0] w0, w1;
    logic [31:0]  addr;
    bit ok;
    int r, op, size, idx;

    rstn = 1'b0; a_valid = 1'b0; d_ready = 1'b0;
    a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
    a_address = '0; a_mask = '0; a_data = '0; a_corrupt = 1'b0;

    for (int i = 0; i < DP; i++) model[i] = {$urandom, $urandom, $urandom, $urandom};
    model[0] = 128'h00112233445566778899AABBCCDDEEFF;
    for (int i = 0; i < DP; i++) dut.ram[i] = model[i];

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_a_ready", 128'(a_ready), 128'd0);
    checkOutput("rst_d_valid", 128'(d_valid), 128'd0);
    checkOutput("rst_d_data", d_data, 128'd0);
    checkOutput("rst_d_fields", 128'({d_opcode, d_size, d_source, d_denied}), 128'd0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    // Preloaded word via Get, upper address bits ignored.
    dq = {128'd0}; mq = {16'h0};
    applyStimulus(4, 4, 5, 32'h8000_0000, dq, mq, 0);

    // Single-byte PutPartialData then readback.
    dq = {128'hA5}; mq = {16'h0001};
    applyStimulus(1, 4, 2, 32'h10, dq, mq, 0);
    applyStimulus(4, 4, 2, 32'h10, dq, mq, 0);

    // Four-beat PutFullData then burst readback.
    dq = {128'd1, 128'd2, 128'd3, 128'd4};
    mq = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    applyStimulus(0, 6, 7, 32'h100, dq, mq, 1);
    applyStimulus(4, 6, 7, 32'h100, dq, mq, 0);

    // Back-pressured two-beat Get, and index wrap at the top of the RAM.
    applyStimulus(4, 5, 1, 32'h100, dq, mq, 3);
    applyStimulus(4, 5, 4, 32'h3FFF0, dq, mq, 0);

    // Unsupported opcode and oversized Get are denied and leave memory alone.
    dq = {128'hDEAD}; mq = {16'hFFFF};
    applyStimulus(2, 4, 6, 32'h40, dq, mq, 0);
    applyStimulus(4, 9, 3, 32'h40, dq, mq, 0);
    applyStimulus(4, 4, 3, 32'h40, dq, mq, 0);

    // Reset in the middle of a write burst.
    w0 = {$urandom, $urandom, $urandom, $urandom};
    w1 = {$urandom, $urandom, $urandom, $urandom};
    send_a(3'd0, 8'd6, 3'd3, 32'h200, 16'hFFFF, w0, ok);
    model[32] = w0;
    send_a(3'd0, 8'd6, 3'd3, 32'($urandom), 16'hFFFF, w1, ok);
    model[33] = w1;
    #2 rstn = 1'b0;
    #1;
    checkOutput("midrst_a_ready", 128'(a_ready), 128'd0);
    checkOutput("midrst_d_valid", 128'(d_valid), 128'd0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    checkOutput("postrst_a_ready", 128'(a_ready), 128'd1);
    checkOutput("postrst_d_valid", 128'(d_valid), 128'd0);
    applyStimulus(4, 6, 0, 32'h200, dq, mq, 0);

    // Randomized mix of reads, writes and denied requests.
    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      size = $urandom_range(0, 8);
      if (r <= 3)      op = 4;
      else if (r <= 5) op = 0;
      else if (r <= 7) op = 1;
      else if (r == 8) begin
        op = $urandom_range(2, 7);
        if (op == 4) op = 3;
      end else begin
        op = ($urandom_range(0, 1) == 0) ? 4 : $urandom_range(0, 1);
        size = $urandom_range(9, 12);
      end
      idx = ($urandom_range(0, 3) == 0) ? DP - $urandom_range(1, 4) : $urandom_range(0, 63);
      addr = $urandom;
      addr[17:4] = 14'(idx);
      dq = {}; mq = {};
      for (int b = 0; b < 16; b++) begin
        dq.push_back({$urandom, $urandom, $urandom, $urandom});
        mq.push_back((op == 0 && $urandom_range(0, 3) != 0) ? 16'hFFFF : 16'($urandom));
      end
      applyStimulus(op, size, $urandom_range(0, 7), addr, dq, mq, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
